// File: rtl/mic_pkg.sv
// Shared types and frame constants for the I2S microphone capture controller.
package mic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;
    localparam int BITCNT_W   = $clog2(FRAME_BITS);

endpackage

// File: rtl/mic_clk_gen.sv
// Bit-clock divider: toggles mclk every CLK_DIV cycles while run is high, held low otherwise.
module mic_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic mclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          edge_due;

    // Strobes are high in the cycle whose closing edge flips mclk, so logic
    // keyed to them updates on the same clk edge as the mclk transition.
    assign edge_due  = run && (div_cnt == DW'(CLK_DIV - 1));
    assign rise_tick = edge_due && !mclk;
    assign fall_tick = edge_due && mclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
        end else if (edge_due) begin
            div_cnt <= '0;
            mclk    <= ~mclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mic_capture_ctrl.sv
// I2S MEMS mic capture: frames dataint into samples with valid/ready, block count and overflow.
// Define MIC_STEREO_EN to capture both slots and add the sample_ch output.
module mic_capture_ctrl
    import mic_pkg::*;
#(
    parameter int CLK_DIV   = 25,
    parameter int SAMPLE_W  = 24,
    parameter int BLOCK_LEN = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                dataint,
    input  logic                sample_ready,
    input  logic                clear_ovf,
    output logic                mclk,
    output logic                ws,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    output logic                block_done,
    output logic                overflow,
    output logic                busy
`ifdef MIC_STEREO_EN
    ,
    output logic                sample_ch
`endif
);

    localparam int              BW       = $clog2(BLOCK_LEN + 1);
    localparam logic [BITCNT_W-2:0] LAST_POS = (BITCNT_W-1)'(SAMPLE_W);

    state_t              state, state_nxt;
    logic                run, rise_tick, fall_tick;
    logic [BITCNT_W-1:0] bitcnt;
    logic [BITCNT_W-2:0] slot_pos;
    logic                slot, capture_slot, in_window, complete, accept, xfer;
    logic [SAMPLE_W-1:0] shifter, shift_nxt;
    logic [SAMPLE_W:0]   shift_ext;
    logic [BW-1:0]       blk_cnt;

    mic_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mclk      (mclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign run      = (state == ST_RUN);
    assign busy     = run;
    assign slot     = bitcnt[BITCNT_W-1];
    assign slot_pos = bitcnt[BITCNT_W-2:0];
    assign ws       = slot;

`ifdef MIC_STEREO_EN
    assign capture_slot = 1'b1;
`else
    assign capture_slot = !slot;
`endif

    // Slot bit 0 is the I2S one-bit delay; data occupies slot bits 1..SAMPLE_W.
    assign in_window = capture_slot && (slot_pos != '0) && (slot_pos <= LAST_POS);
    assign complete  = rise_tick && in_window && (slot_pos == LAST_POS);
    assign shift_ext = {shifter, dataint};
    assign shift_nxt = shift_ext[SAMPLE_W-1:0];
    assign xfer      = sample_valid && sample_ready;
    assign accept    = !sample_valid || sample_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            // Stop only at the frame wrap so a started frame always completes.
            ST_RUN:  if (fall_tick && (bitcnt == '1) && !enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt  <= '0;
            shifter <= '0;
        end else begin
            if (!run)          bitcnt <= '0;
            else if (fall_tick) bitcnt <= bitcnt + 1'b1;
            if (rise_tick && in_window) shifter <= shift_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
`ifdef MIC_STEREO_EN
            sample_ch    <= 1'b0;
`endif
        end else begin
            if (complete && accept) begin
                sample_data  <= shift_nxt;
                sample_valid <= 1'b1;
`ifdef MIC_STEREO_EN
                sample_ch    <= slot;
`endif
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (complete && !accept) overflow <= 1'b1;
            else if (clear_ovf)      overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt    <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (xfer) begin
                if (blk_cnt == BW'(BLOCK_LEN - 1)) begin
                    blk_cnt    <= '0;
                    block_done <= 1'b1;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Randomized bench for mic_capture_ctrl with a frame-timing reference model and literal pins.
module tb_mic_capture_ctrl;

    localparam int D     = 2;
    localparam int SW    = 24;
    localparam int BL    = 4;
    localparam int FB    = 2 * D;
    localparam int FRAME = 64 * FB;
`ifdef MIC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          dataint;
    logic          sample_ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          mclk, ws, sample_valid, block_done, overflow, busy;
    logic [SW-1:0] sample_data;
`ifdef MIC_STEREO_EN
    logic          sample_ch;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int bd_total = 0;
    int xf_rst = 0;

    mic_capture_ctrl #(.CLK_DIV(D), .SAMPLE_W(SW), .BLOCK_LEN(BL)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dataint      (dataint),
        .sample_ready (sample_ready),
        .clear_ovf    (clear_ovf),
        .mclk         (mclk),
        .ws           (ws),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .block_done   (block_done),
        .overflow     (overflow),
        .busy         (busy)
`ifdef MIC_STEREO_EN
        ,
        .sample_ch    (sample_ch)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (time since RUN entry -> frame position)
    logic          m_run, m_valid, m_ovf, m_bd, m_fstart, m_ch;
    logic [SW-1:0] m_data, cur_l, cur_r, nxt_l, nxt_r, m_word;
    int            m_k, m_nx, m_pos, m_bit;
    logic          m_slot, m_rise, m_fall, m_done, m_load, m_drop, m_xfer, junk;
    logic          e_mclk, e_ws;
    logic [4:0]    m_idx;

    always @(negedge clk) junk <= 1'($urandom);

    always_comb begin
        m_pos  = (m_k / FB) % 64;
        m_slot = (m_pos >= 32);
        m_bit  = m_pos % 32;
        m_rise = m_run && ((m_k % FB) == D - 1);
        m_fall = m_run && ((m_k % FB) == FB - 1);
        m_word = m_slot ? cur_r : cur_l;
        m_done = m_rise && (m_bit == SW) && (STEREO || !m_slot);
        m_load = m_done && (!m_valid || sample_ready);
        m_drop = m_done && m_valid && !sample_ready;
        m_xfer = m_valid && sample_ready;
        e_mclk = m_run && (((m_k / D) % 2) == 1);
        e_ws   = m_run && m_slot;
        m_idx  = 5'(SW - m_bit);
        dataint = junk;
        if (m_run && (m_bit >= 1) && (m_bit <= SW)) dataint = m_word[m_idx];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; m_k <= 0; m_valid <= 1'b0; m_data <= '0; m_ch <= 1'b0;
            m_ovf <= 1'b0; m_bd <= 1'b0; m_nx <= 0; m_fstart <= 1'b0;
        end else begin
            m_fstart <= 1'b0;
            if (m_load) begin
                m_valid <= 1'b1; m_data <= m_word; m_ch <= m_slot;
            end else if (m_xfer) begin
                m_valid <= 1'b0;
            end
            if (m_drop)         m_ovf <= 1'b1;
            else if (clear_ovf) m_ovf <= 1'b0;
            m_bd <= m_xfer && (((m_nx + 1) % BL) == 0);
            if (m_xfer) m_nx <= m_nx + 1;
            if (!m_run) begin
                if (enable) begin
                    m_run <= 1'b1; m_k <= 0; cur_l <= nxt_l; cur_r <= nxt_r; m_fstart <= 1'b1;
                end
            end else if (m_fall && (m_pos == 63)) begin
                m_k <= 0;
                if (!enable) m_run <= 1'b0;
                else begin
                    cur_l <= nxt_l; cur_r <= nxt_r; m_fstart <= 1'b1;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge clk) begin
        chk("mclk",         32'(mclk),         32'(e_mclk));
        chk("ws",           32'(ws),           32'(e_ws));
        chk("busy",         32'(busy),         32'(m_run));
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("sample_data",  32'(sample_data),  32'(m_data));
        chk("block_done",   32'(block_done),   32'(m_bd));
        chk("overflow",     32'(overflow),     32'(m_ovf));
`ifdef MIC_STEREO_EN
        chk("sample_ch",    32'(sample_ch),    32'(m_ch));
`endif
    end

    always @(negedge clk) begin
        if (reset) xf_rst <= 0;
        else begin
            if (block_done) begin
                chk("block_done_boundary", 32'(xf_rst % BL), 32'd0);
                bd_total <= bd_total + 1;
            end
            if (sample_valid && sample_ready) xf_rst <= xf_rst + 1;
        end
    end

    // ---------------- stimulus helpers
    task automatic wait_xfer(output logic [SW-1:0] d, output logic ch, output int c);
        bit ok;
        ok = 1'b0; d = '0; ch = 1'b0; c = 0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            if (sample_valid && sample_ready) begin
                d = sample_data;
`ifdef MIC_STEREO_EN
                ch = sample_ch;
`endif
                c = cyc; ok = 1'b1;
                break;
            end
        end
        chk("xfer_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_fstart();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(posedge clk); #1;
            if (m_fstart) begin ok = 1'b1; break; end
        end
        chk("frame_start_seen", 32'(ok), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mclk"},  32'(mclk), 0);
        chk({tag, "_ws"},    32'(ws), 0);
        chk({tag, "_data"},  32'(sample_data), 0);
        chk({tag, "_valid"}, 32'(sample_valid), 0);
        chk({tag, "_bdone"}, 32'(block_done), 0);
        chk({tag, "_ovf"},   32'(overflow), 0);
        chk({tag, "_busy"},  32'(busy), 0);
`ifdef MIC_STEREO_EN
        chk({tag, "_ch"},    32'(sample_ch), 0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] d, w;
        logic          ch;
        int            c, c0, n;
        bit            stall;
        nxt_l = '0; nxt_r = '0;

        repeat (3) @(posedge clk); #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Fixed pattern, continuous accept: sample content, period, block pulses.
        nxt_l = 24'hA5C3F1; nxt_r = 24'hFFFFFF; sample_ready = 1'b1; enable = 1'b1;
        c0 = 0;
        for (int i = 0; i < 12; i++) begin
            wait_xfer(d, ch, c);
            chk("fixed_data", 32'(d), (STEREO && (i % 2 == 1)) ? 32'hFFFFFF : 32'hA5C3F1);
`ifndef MIC_STEREO_EN
            if (i == 1) chk("mono_period", 32'(c - c0), 32'(FRAME));
`endif
            c0 = c;
        end
        repeat (3) @(negedge clk);
        chk("block_done_count", 32'(bd_total), 32'd3);

        // Consumer stall across two frames: first sample held, second dropped.
        @(posedge clk); #1;
        nxt_l = 24'h000001; nxt_r = 24'h000007;
        wait_fstart();
        sample_ready = 1'b0; nxt_l = 24'h000002;
        wait_fstart();
        wait_fstart();
        chk("stall_data", 32'(sample_data), 32'h000001);
        chk("stall_ovf", 32'(overflow), 32'd1);
        chk("stall_valid", 32'(sample_valid), 32'd1);
        clear_ovf = 1'b1;
        @(posedge clk); #1;
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        sample_ready = 1'b1;

        // Randomized traffic: words, ready jitter, stalled frames, clears, enable drops.
        for (int f = 0; f < 20; f++) begin
            nxt_l = SW'($urandom); nxt_r = SW'($urandom);
            stall = ($urandom % 4 == 0);
            enable = ($urandom % 6 != 0);
            repeat (FRAME) begin
                @(posedge clk); #1;
                sample_ready = stall ? 1'b0 : ($urandom % 4 != 0);
                clear_ovf = ($urandom % 64 == 0);
            end
        end
        enable = 1'b1; sample_ready = 1'b1; clear_ovf = 1'b0;

        // Enable dropped at bitcnt 10: frame completes, then IDLE.
        wait_fstart();
        repeat (10 * FB) @(posedge clk);
        #1;
        enable = 1'b0;
        n = 10 * FB;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        chk("stop_latency", 32'(n), 32'(FRAME));
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_mclk", 32'(mclk), 0);
        chk("idle_ws", 32'(ws), 0);

        // Reset at bitcnt 40 with a pending sample, then a clean restart.
        sample_ready = 1'b0; enable = 1'b1;
        wait_fstart();
        repeat (40 * FB) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(sample_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        w = SW'($urandom); nxt_l = w; nxt_r = ~w;
        sample_ready = 1'b1;
        reset = 1'b0;
        wait_xfer(d, ch, c);
        chk("post_reset_sample", 32'(d), 32'(w));

`ifdef MIC_STEREO_EN
        // Both slots in order with their channel tags.
        @(posedge clk); #1;
        nxt_l = 24'h123456; nxt_r = 24'h654321;
        wait_fstart();
        wait_xfer(d, ch, c);
        chk("stereo_left_data", 32'(d), 32'h123456);
        chk("stereo_left_ch", 32'(ch), 32'd0);
        wait_xfer(d, ch, c);
        chk("stereo_right_data", 32'(d), 32'h654321);
        chk("stereo_right_ch", 32'(ch), 32'd1);
`endif

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
